// File: rtl/sop2_align_pipe_pkg.sv
// Shared constants and width helpers for the sop2_align_pipe sum-of-products engine.
package sop2_pkg;

    localparam int ACC_GUARD = 8;

    function automatic int sop_max(input int x, input int y);
        return (x > y) ? x : y;
    endfunction

    function automatic int sop_absdiff(input int x, input int y);
        return (x > y) ? (x - y) : (y - x);
    endfunction

    function automatic int sop_prod_w(input int w);
        return 2 * w;
    endfunction

    // One extra bit over a product so the two-term sum can never overflow.
    function automatic int sop_sum_w(input int w);
        return 2 * w + 1;
    endfunction

    function automatic int sop_acc_w(input int w);
        return 2 * w + 1 + ACC_GUARD;
    endfunction

endpackage

// File: rtl/sop2_align_pipe_if.sv
// Operand/result bus of sop2_align_pipe; accumulator signals exist only with SOP2_ACCUM_EN.
interface sop2_align_pipe_if #(
    parameter int W = 8
);
    import sop2_pkg::*;

    logic                      in_valid;
    logic [W-1:0]              a;
    logic [W-1:0]              b;
    logic [W-1:0]              c;
    logic [W-1:0]              d;
    logic                      out_valid;
    logic [sop_sum_w(W)-1:0]   s;
    logic                      busy;
`ifdef SOP2_ACCUM_EN
    logic                      acc_first;
    logic [sop_acc_w(W)-1:0]   acc;
    logic                      acc_valid;

    modport master (output in_valid, a, b, c, d, acc_first,
                    input  out_valid, s, busy, acc, acc_valid);
    modport slave  (input  in_valid, a, b, c, d, acc_first,
                    output out_valid, s, busy, acc, acc_valid);
`else
    modport master (output in_valid, a, b, c, d,
                    input  out_valid, s, busy);
    modport slave  (input  in_valid, a, b, c, d,
                    output out_valid, s, busy);
`endif

endinterface

// File: rtl/sop2_align_pipe_delay.sv
// Reset-cleared shift register of DEPTH stages; DEPTH = 0 collapses to a plain wire.
module pipe_delay_line #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    generate
        if (DEPTH == 0) begin : g_wire
            wire unused_clk_rst = &{1'b0, clk, rst_n};
            assign dout = din;
        end else begin : g_shift
            logic [WIDTH-1:0] stage [DEPTH];

            // NOTE: every stage is cleared on reset (not just the head), so no stale
            // data can leak out after a mid-stream reset; this stops RAM inference on purpose.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
                end else begin
                    // NOTE: non-blocking assignments let every stage read its
                    // predecessor's old value, giving a true shift regardless of order.
                    stage[0] <= din;
                    for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
                end
            end

            assign dout = stage[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/sop2_align_pipe.sv
// Two-term sum of products s = a*b + c*d with per-path latency and internal alignment.
// Optional running accumulator of s is enabled by defining SOP2_ACCUM_EN.
module sop2_align_pipe
    import sop2_pkg::*;
#(
    parameter int W      = 8,
    parameter int LAT_AB = 3,
    parameter int LAT_CD = 9,
    parameter int SIGNED = 0
) (
    input  logic                clk,
    input  logic                rst_n,
    sop2_align_pipe_if.slave    bus
);

    localparam int PW     = sop_prod_w(W);
    localparam int SW     = sop_sum_w(W);
    localparam int L      = sop_max(LAT_AB, LAT_CD);
    localparam int ALN_AB = (LAT_AB < LAT_CD) ? sop_absdiff(LAT_AB, LAT_CD) : 0;
    localparam int ALN_CD = (LAT_CD < LAT_AB) ? sop_absdiff(LAT_AB, LAT_CD) : 0;

    logic [PW-1:0] p_ab, p_cd;
    logic [PW-1:0] pipe_ab, pipe_cd;
    logic [PW-1:0] al_ab, al_cd;
    logic [SW-1:0] ext_ab, ext_cd, sum_next;
    logic [SW-1:0] s_q;
    logic [L:0]    valid_pipe;

    // Operands are widened to the product width first so the low 2W bits are exact.
    generate
        if (SIGNED != 0) begin : g_smul
            assign p_ab = $signed({{W{bus.a[W-1]}}, bus.a}) * $signed({{W{bus.b[W-1]}}, bus.b});
            assign p_cd = $signed({{W{bus.c[W-1]}}, bus.c}) * $signed({{W{bus.d[W-1]}}, bus.d});
            assign ext_ab = {al_ab[PW-1], al_ab};
            assign ext_cd = {al_cd[PW-1], al_cd};
        end else begin : g_umul
            assign p_ab = {{W{1'b0}}, bus.a} * {{W{1'b0}}, bus.b};
            assign p_cd = {{W{1'b0}}, bus.c} * {{W{1'b0}}, bus.d};
            assign ext_ab = {1'b0, al_ab};
            assign ext_cd = {1'b0, al_cd};
        end
    endgenerate

    // First stage of each path is the product register; the rest is padding.
    pipe_delay_line #(.WIDTH(PW), .DEPTH(LAT_AB)) u_stage_ab (
        .clk(clk), .rst_n(rst_n), .din(p_ab), .dout(pipe_ab)
    );
    pipe_delay_line #(.WIDTH(PW), .DEPTH(LAT_CD)) u_stage_cd (
        .clk(clk), .rst_n(rst_n), .din(p_cd), .dout(pipe_cd)
    );

    // Only the faster path gets a non-zero alignment depth.
    pipe_delay_line #(.WIDTH(PW), .DEPTH(ALN_AB)) u_align_ab (
        .clk(clk), .rst_n(rst_n), .din(pipe_ab), .dout(al_ab)
    );
    pipe_delay_line #(.WIDTH(PW), .DEPTH(ALN_CD)) u_align_cd (
        .clk(clk), .rst_n(rst_n), .din(pipe_cd), .dout(al_cd)
    );

    assign sum_next = ext_ab + ext_cd;

    // valid_pipe[k] tracks the beat sitting in data stage k+1; bit L is the sum register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_pipe <= '0;
            s_q        <= '0;
        end else begin
            valid_pipe <= {valid_pipe[L-1:0], bus.in_valid};
            if (valid_pipe[L-1]) s_q <= sum_next;
        end
    end

    assign bus.s         = s_q;
    assign bus.out_valid = valid_pipe[L];
    assign bus.busy      = |valid_pipe;

`ifdef SOP2_ACCUM_EN
    localparam int AW = sop_acc_w(W);

    logic          first_al;
    logic [AW-1:0] ext_sum;
    logic [AW-1:0] acc_q;

    // acc_first rides L stages so it meets its own sum at the sum register.
    pipe_delay_line #(.WIDTH(1), .DEPTH(L)) u_first_pipe (
        .clk(clk), .rst_n(rst_n), .din(bus.acc_first), .dout(first_al)
    );

    generate
        if (SIGNED != 0) begin : g_sacc
            assign ext_sum = {{ACC_GUARD{sum_next[SW-1]}}, sum_next};
        end else begin : g_uacc
            assign ext_sum = {{ACC_GUARD{1'b0}}, sum_next};
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else if (valid_pipe[L-1]) begin
            acc_q <= first_al ? ext_sum : acc_q + ext_sum;
        end
    end

    assign bus.acc       = acc_q;
    assign bus.acc_valid = valid_pipe[L];
`endif

endmodule
